// File: rtl/fb_write_sched.sv
// Round-robin arbiter for the framebuffer write port, gated to vertical blanking.
// Define FB_ACTIVE_WRITE_EN to open the write window in every state.
module fb_write_sched #(
    parameter int NREQ    = 4,
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int VACTIVE = 480,
    parameter int VTOTAL  = 525,
    parameter int GUARD   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           vc,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic                 window,
    output logic                 frame_start,
    output logic [15:0]          wr_count
);

    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] ACTIVE = 2'd0;
    localparam logic [1:0] BLANK  = 2'd1;
    localparam logic [1:0] CLOSE  = 2'd2;

    localparam logic [9:0] VC_OPEN = 10'(VACTIVE);
    localparam logic [9:0] VC_SHUT = 10'(VTOTAL - GUARD);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic          open_edge;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [15:0]   cnt_base;
    logic [15:0]   cnt_nx;

    assign open_edge = (state == ACTIVE) && (vc == VC_OPEN);

    always_comb begin
        state_nx = state;
        case (state)
            ACTIVE: if (open_edge) state_nx = BLANK;
            BLANK:  if (vc == VC_SHUT) state_nx = CLOSE;
            CLOSE:  if (vc == 10'd0) state_nx = ACTIVE;
            default: state_nx = ACTIVE;
        endcase
    end

`ifdef FB_ACTIVE_WRITE_EN
    assign window = ~rst;
`else
    assign window = ~rst & (state == BLANK);
`endif

    // Two passes: indices above ptr first, then wrap to 0..ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req[i] && (PW'(i) > ptr)) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req[i] && (PW'(i) <= ptr)) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        gnt = (window && gnt_any) ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Clear at window entry happens before the increment of a same-cycle grant.
    always_comb begin
        cnt_base = open_edge ? 16'd0 : wr_count;
        cnt_nx   = cnt_base;
        if (|gnt && cnt_base != 16'hFFFF)
            cnt_nx = cnt_base + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACTIVE;
            ptr         <= PW'(NREQ - 1);
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            wr_count    <= 16'd0;
        end else begin
            state       <= state_nx;
            frame_start <= open_edge;
            wr_en       <= |gnt;
            wr_count    <= cnt_nx;
            if (|gnt) begin
                ptr     <= gnt_idx;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
- Schedules and shares the single framebuffer write port (address / color / writeEnable into the VGA frame RAM) between NREQ graphics requesters, e.g. maze painter, pacman sprite and ghost sprites.
- Writes are granted only inside a vertical-blanking window derived from the VGA line counter, so the display never shows a half-drawn frame.
- Arbitration is round-robin, one write per clk. The write port outputs are registered.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 16, framebuffer address width.
- DW, 8, pixel data width (RGB 3-3-2).
- VACTIVE, 480, first blanking line number.
- VTOTAL, 525, lines per frame; vc ranges 0..VTOTAL-1.
- GUARD, 2, lines before VTOTAL at which the write window closes.

Ports:
- clk  in  1  pixel clock (vgaclk domain)
- rst  in  1  reset; asynchronous, active-high
- vc  in  10  current VGA line counter
- req  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed pixel data; requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant; a write is accepted in any cycle where gnt[i]=1
- wr_en  out  1  framebuffer write enable (registered)
- wr_addr  out  AW  framebuffer write address (registered)
- wr_data  out  DW  framebuffer write data (registered)
- window  out  1  1 while writes are permitted
- frame_start  out  1  one-cycle pulse on entry to the blanking window
- wr_count  out  16  writes accepted in the current window; saturates at 0xFFFF

Behaviour:
- Reset (async, rst=1):
  - Outputs: gnt=0, wr_en=0, wr_addr=0, wr_data=0, window=0, frame_start=0, wr_count=0.
  - State=ACTIVE; rr pointer=NREQ-1, so requester 0 wins first.
  - Reset mid-write drops any in-flight write. wr_en is 0 on the first clk after release.
- FSM (registered), states ACTIVE, BLANK, CLOSE:
  - ACTIVE -> BLANK when vc==VACTIVE. frame_start pulses that cycle; wr_count clears to 0 that cycle.
  - BLANK -> CLOSE when vc==VTOTAL-GUARD.
  - CLOSE -> ACTIVE when vc==0.
  - window=1 only in BLANK.
  - If vc jumps without hitting a trigger value, the state holds.
- Grant (combinational from req and registered state/pointer):
  - If window=0, gnt=0.
  - Otherwise gnt is one-hot for the first i with req[i]=1, searching ptr+1, ptr+2, … modulo NREQ.
  - If no request, gnt=0.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt[i]=1.
  - It may drop req or present the next pixel on the following cycle.
  - req deasserted without a grant is allowed (request withdrawn).
- On grant of i:
  - ptr<=i.
  - Next cycle: wr_en=1, wr_addr=req_addr[i], wr_data=req_data[i]. Latency is 1 clk from grant to write.
  - wr_count<=wr_count+1, saturating.
- With no grant, wr_en<=0 next cycle.
- A continuously requesting requester gets 1 of every k cycles, where k is the number of active requesters. No starvation.
- A grant in the last BLANK cycle still writes on the next cycle, inside the GUARD lines.
- Simultaneous frame_start and grant: the count is cleared, then incremented, so wr_count=1.

Optional Feature:
- Macro: FB_ACTIVE_WRITE_EN.
- Defined: window=1 in every state, so writes are granted continuously (debug/tearing allowed). frame_start and the FSM still run; wr_count still clears at BLANK entry.
- Undefined: window=1 only in BLANK, as above.

Test Plan:
- Reset release, then vc sweep 0->524:
  - frame_start pulses once at vc=480.
  - window=1 for vc 480..522 and 0 elsewhere.
- req=4'b0001 with addr 0x1234 and data 0xE0 during ACTIVE (vc=100):
  - gnt=0 and wr_en=0 until vc=480.
  - Then gnt=0001, and the next cycle shows wr_en=1, wr_addr=0x1234, wr_data=0xE0.
- req=4'b1111 held in BLANK:
  - Grant order 0,1,2,3,0,… (one per clk).
  - After 8 cycles wr_count=8.
- req=4'b0101 in BLANK: grants alternate 0001, 0100.
- Assert rst mid-BLANK with a grant pending:
  - All outputs 0 immediately (async).
  - After release the state is ACTIVE, and the first grant in the next window goes to requester 0.
- With FB_ACTIVE_WRITE_EN defined, req=0010 at vc=50: gnt=0010, and wr_en=1 on the next cycle.
